// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the burst read/write flow controller:
//   - state encoding of the controller FSM (3-bit)
//   - default values for the controller parameters
// -----------------------------------------------------------------------------
package ctrl_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t WR       = 3'd1;
  localparam state_t RD_ACC   = 3'd2;
  localparam state_t RD_LOAD  = 3'd3;
  localparam state_t RD_WAIT  = 3'd4;
  localparam state_t DIR_LOAD = 3'd5;
  localparam state_t DIR_WAIT = 3'd6;

  localparam int ADDR_W_DEFAULT = 4;
  localparam int LEN_W_DEFAULT  = 3;
  localparam int TO_W_DEFAULT   = 8;

endpackage

// File: rtl/ctrl_ptr_unit.sv
// -----------------------------------------------------------------------------
// ctrl_ptr_unit
// Circular result-memory bookkeeping: write pointer, read pointer and
// occupancy count, with full/empty decode.
//   clk, reset     : clock, asynchronous active-high reset
//   inc_wr         : one word written (advance wr_ptr, count + 1)
//   inc_rd         : one word consumed (advance rd_ptr, count - 1)
//   wr_ptr, rd_ptr : ADDR_W-bit pointers, wrap modulo 2^ADDR_W
//   count          : ADDR_W+1 bits, 0 .. 2^ADDR_W
//   full, empty    : count == 2^ADDR_W / count == 0
// The controller never raises both strobes in the same cycle.
// -----------------------------------------------------------------------------
module ctrl_ptr_unit
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_wr,
  input  logic              inc_rd,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (inc_wr) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      count  <= count + (ADDR_W+1)'(1);
    end else if (inc_rd) begin
      rd_ptr <= rd_ptr + ADDR_W'(1);
      count  <= count - (ADDR_W+1)'(1);
    end
  end

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

endmodule

// File: rtl/control_rw_burst.sv
// -----------------------------------------------------------------------------
// control_rw_burst
// Flow controller for the calculator result path.
//   mode 1: write the current result into a circular result memory, or read
//           back a burst of words, each serialised through the parallel-load
//           transmitter.
//   mode 0: transmit the current result directly.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   valid_cmd, rw, mode  : command strobe (sampled in IDLE), direction, mode
//   active               : calculator enable; low aborts any operation
//   burst_len [LEN_W]    : words to read, 0 = all stored words
//   tx_done              : transmitter idle flag (1 = idle)
//   ac_mem, rw_mem       : memory access enable / direction (1 = write)
//   mem_addr [ADDR_W]    : wr_ptr in WR, rd_ptr otherwise
//   p_load, tx_dat       : parallel load / start transmission
//   busy                 : high in every non-IDLE state
//   mem_full, mem_empty  : occupancy decode
//   cmd_err              : one-cycle pulse on a rejected or aborted command
// Build option:
//   CTRL_TIMEOUT_EN      : adds a TO_W-bit watchdog on the transmitter waits;
//                          when undefined the controller waits indefinitely
//                          and TO_W has no effect.
// -----------------------------------------------------------------------------
module control_rw_burst
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT,
  parameter int TO_W   = TO_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_cmd,
  input  logic              rw,
  input  logic              active,
  input  logic              mode,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              tx_done,
  output logic              ac_mem,
  output logic              rw_mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              p_load,
  output logic              tx_dat,
  output logic              busy,
  output logic              mem_full,
  output logic              mem_empty,
  output logic              cmd_err
);

  localparam int CNT_W = ADDR_W + 1;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   remaining, remaining_nxt;
  logic [CNT_W-1:0]   req_len;
  logic               full, empty;
  logic               seen_busy, seen_busy_nxt;
  logic               err_nxt;
  logic               in_wait;
  logic               exp_mode;
  logic               abort;
  logic               wd_expired;

  ctrl_ptr_unit #(.ADDR_W(ADDR_W)) u_ptr (
    .clk    (clk),
    .reset  (reset),
    .inc_wr (state == WR),
    .inc_rd (state == RD_ACC),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign in_wait  = (state == RD_WAIT) || (state == DIR_WAIT);
  // Each non-IDLE state belongs to one mode; a mode flip mid-operation aborts.
  assign exp_mode = !((state == DIR_LOAD) || (state == DIR_WAIT));
  assign abort    = (state != IDLE) && (!active || (mode != exp_mode));

  // Words to read: all stored words when burst_len is 0 or asks for more.
  always_comb begin
    if ((burst_len == '0) || (int'(burst_len) > int'(count)))
      req_len = count;
    else
      req_len = CNT_W'(burst_len);
  end

`ifdef CTRL_TIMEOUT_EN
  localparam logic [TO_W-1:0] WD_PRE_TERM = ~TO_W'(1);

  logic [TO_W-1:0] wd_cnt;

  // Cleared in the LOAD state that always precedes a wait, so it starts from
  // zero on every entry to RD_WAIT / DIR_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if ((state == RD_LOAD) || (state == DIR_LOAD))
      wd_cnt <= '0;
    else if (in_wait)
      wd_cnt <= wd_cnt + TO_W'(1);
  end

  // Leave on the cycle whose increment reaches the terminal count.
  assign wd_expired = in_wait && (wd_cnt == WD_PRE_TERM);
`else
  assign wd_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic, including the remaining/seen_busy/error updates.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    seen_busy_nxt = seen_busy;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (valid_cmd && active) begin
          if (mode) begin
            if (rw) begin
              if (full) err_nxt   = 1'b1;
              else      state_nxt = WR;
            end else if (empty) begin
              err_nxt = 1'b1;
            end else if (tx_done) begin
              state_nxt     = RD_ACC;
              remaining_nxt = req_len;
            end
          end else if (tx_done) begin
            state_nxt = DIR_LOAD;
          end
        end
      end
      WR: state_nxt = IDLE;
      RD_ACC: begin
        remaining_nxt = remaining - CNT_W'(1);
        state_nxt     = RD_LOAD;
      end
      RD_LOAD, DIR_LOAD: begin
        seen_busy_nxt = 1'b0;
        state_nxt     = (state == RD_LOAD) ? RD_WAIT : DIR_WAIT;
      end
      RD_WAIT, DIR_WAIT: begin
        if (!tx_done) seen_busy_nxt = 1'b1;
        // A tx_done that never dropped since the load is stale: keep waiting.
        if (seen_busy && tx_done) begin
          state_nxt = ((state == RD_WAIT) && (remaining != '0)) ? RD_ACC : IDLE;
        end else if (wd_expired) begin
          state_nxt     = IDLE;
          err_nxt       = 1'b1;
          remaining_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Consumed words stay consumed: pointers are not touched here.
    if (abort) begin
      state_nxt     = IDLE;
      err_nxt       = 1'b1;
      remaining_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      seen_busy <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      remaining <= remaining_nxt;
      seen_busy <= seen_busy_nxt;
      cmd_err   <= err_nxt;
    end
  end

  // Moore output decode.
  always_comb begin
    ac_mem   = 1'b0;
    rw_mem   = 1'b0;
    p_load   = 1'b0;
    tx_dat   = 1'b0;
    busy     = (state != IDLE);
    mem_addr = rd_ptr;
    case (state)
      WR: begin
        ac_mem   = 1'b1;
        rw_mem   = 1'b1;
        mem_addr = wr_ptr;
      end
      RD_ACC: ac_mem = 1'b1;
      RD_LOAD, DIR_LOAD: begin
        p_load = 1'b1;
        tx_dat = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_full  = full;
  assign mem_empty = empty;

endmodule

// File: tb/tb_control_rw_burst.sv
module tb_control_rw_burst;

  localparam int ADDR_W = 4;
  localparam int LEN_W  = 3;
  localparam int TO_W   = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_cmd, rw, active, mode, tx_done;
  logic [LEN_W-1:0]  burst_len;
  logic              ac_mem, rw_mem, p_load, tx_dat, busy;
  logic              mem_full, mem_empty, cmd_err;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  control_rw_burst #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_cmd (valid_cmd),
    .rw        (rw),
    .active    (active),
    .mode      (mode),
    .burst_len (burst_len),
    .tx_done   (tx_done),
    .ac_mem    (ac_mem),
    .rw_mem    (rw_mem),
    .mem_addr  (mem_addr),
    .p_load    (p_load),
    .tx_dat    (tx_dat),
    .busy      (busy),
    .mem_full  (mem_full),
    .mem_empty (mem_empty),
    .cmd_err   (cmd_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- transmitter model ----------------
  // After each load: stale_cfg cycles still showing idle, then time_cfg busy
  // cycles, then idle again. tx_hang keeps it busy until released.
  int stale_cfg = 0, time_cfg = 1, stale_left = 0, busy_left = 0;
  bit tx_hang = 1'b0;

  initial begin
    tx_done = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (stale_left > 0) begin
        stale_left--; tx_done = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--; tx_done = 1'b0;
      end else begin
        tx_done = 1'b1;
      end
      if (tx_dat) begin
        stale_left = stale_cfg;
        busy_left  = tx_hang ? 1000000 : time_cfg;
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    int err; int words; int first; int loads; int cycles; int full; int empty;
  } exp_t;

  typedef struct packed {
    int kind; int len; int s; int t; exp_t e;
  } vec_t;

  localparam int K_WR = 0, K_RD = 1, K_DIR = 2, K_OFF = 3;

  int m_wp, m_rp, m_occ;

  function automatic exp_t model_step(input int kind, input int len, input int s, input int t);
    exp_t e;
    int n;
    e = '{default: 0};
    case (kind)
      K_WR: if (m_occ == DEPTH) e.err = 1;
            else begin
              e.words = 1; e.first = m_wp; e.cycles = 1;
              m_wp = (m_wp + 1) % DEPTH; m_occ++;
            end
      K_RD: if (m_occ == 0) e.err = 1;
            else begin
              n = (len == 0 || len > m_occ) ? m_occ : len;
              e.words = n; e.first = m_rp; e.loads = n; e.cycles = n * (3 + s + t);
              m_rp = (m_rp + n) % DEPTH; m_occ -= n;
            end
      K_DIR: begin e.loads = 1; e.cycles = 2 + s + t; end
      default: ;
    endcase
    e.full  = (m_occ == DEPTH) ? 1 : 0;
    e.empty = (m_occ == 0) ? 1 : 0;
    return e;
  endfunction

  // ---------------- command driver / observer ----------------
  int obs_addr[$];
  int obs_err, obs_load, obs_cycles, obs_bad;
  bit obs_done;

  task automatic do_cmd(input bit m, input bit r, input int len, input bit act, input int s, input int t);
    stale_cfg = s; time_cfg = t;
    mode = m; rw = r; burst_len = LEN_W'(len); active = act; valid_cmd = 1'b1;
    @(posedge clk); #1;
    valid_cmd = 1'b0; active = 1'b1;
    obs_addr.delete();
    obs_err = 0; obs_load = 0; obs_cycles = 0; obs_bad = 0; obs_done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (ac_mem) begin
        obs_addr.push_back(int'(mem_addr));
        if (rw_mem != r) obs_bad++;
      end
      if (p_load != tx_dat) obs_bad++;
      if (cmd_err) obs_err++;
      if (p_load) obs_load++;
      if (!busy) begin obs_done = 1'b1; break; end
      obs_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_kind(input int kind, input int len, input int s, input int t);
    case (kind)
      K_WR:    do_cmd(1'b1, 1'b1, len, 1'b1, s, t);
      K_RD:    do_cmd(1'b1, 1'b0, len, 1'b1, s, t);
      K_DIR:   do_cmd(1'b0, 1'($urandom_range(0, 1)), len, 1'b1, s, t);
      default: do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len, 1'b0, s, t);
    endcase
  endtask

  task automatic check_obs(input string tag, input exp_t e);
    check({tag, " done"}, int'(obs_done), 1);
    check({tag, " cmd_err"}, obs_err, e.err);
    check({tag, " words"}, obs_addr.size(), e.words);
    foreach (obs_addr[i])
      if (i < e.words) check($sformatf("%s addr%0d", tag, i), obs_addr[i], (e.first + i) % DEPTH);
    check({tag, " loads"}, obs_load, e.loads);
    check({tag, " cycles"}, obs_cycles, e.cycles);
    check({tag, " strobes"}, obs_bad, 0);
    check({tag, " full"}, int'(mem_full), e.full);
    check({tag, " empty"}, int'(mem_empty), e.empty);
  endtask

  task automatic run_model(input int kind, input int len, input int s, input int t, input string tag);
    exp_t e;
    e = model_step(kind, len, s, t);
    do_kind(kind, len, s, t);
    check_obs(tag, e);
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_cmd = 1'b0; active = 1'b1; mode = 1'b1; rw = 1'b0; burst_len = '0;
    tx_hang = 1'b0; stale_left = 0; busy_left = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_wp = 0; m_rp = 0; m_occ = 0;
  endtask

  // Wait (bounded) for the next p_load; returns with the bench in that cycle.
  task automatic wait_load(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (p_load) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({tag, " p_load seen"}, int'(seen), 1);
  endtask

  vec_t vecs[12];

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    // kind, len, stale, txtime, {err, words, first, loads, cycles, full, empty}
    vecs[0]  = '{K_WR,  0, 0, 1, '{0, 1, 0, 0,  1, 0, 0}};
    vecs[1]  = '{K_WR,  0, 0, 1, '{0, 1, 1, 0,  1, 0, 0}};
    vecs[2]  = '{K_WR,  0, 0, 1, '{0, 1, 2, 0,  1, 0, 0}};
    vecs[3]  = '{K_RD,  2, 0, 5, '{0, 2, 0, 2, 16, 0, 0}};
    vecs[4]  = '{K_WR,  0, 0, 1, '{0, 1, 3, 0,  1, 0, 0}};
    vecs[5]  = '{K_WR,  0, 0, 1, '{0, 1, 4, 0,  1, 0, 0}};
    vecs[6]  = '{K_RD,  0, 1, 3, '{0, 3, 2, 3, 21, 0, 1}};
    vecs[7]  = '{K_RD,  3, 0, 1, '{1, 0, 0, 0,  0, 0, 1}};
    vecs[8]  = '{K_DIR, 0, 0, 2, '{0, 0, 0, 1,  4, 0, 1}};
    vecs[9]  = '{K_WR,  0, 0, 1, '{0, 1, 5, 0,  1, 0, 0}};
    vecs[10] = '{K_RD,  7, 0, 1, '{0, 1, 5, 1,  4, 0, 1}};
    vecs[11] = '{K_OFF, 0, 0, 1, '{0, 0, 0, 0,  0, 0, 1}};

    // ---- reset state (async: visible before any clock edge) ----
    reset = 1'b1; valid_cmd = 1'b0; active = 1'b1; mode = 1'b1; rw = 1'b0; burst_len = '0;
    #1;
    check("rst ac_mem", int'(ac_mem), 0);
    check("rst rw_mem", int'(rw_mem), 0);
    check("rst p_load", int'(p_load), 0);
    check("rst tx_dat", int'(tx_dat), 0);
    check("rst busy", int'(busy), 0);
    check("rst cmd_err", int'(cmd_err), 0);
    check("rst mem_full", int'(mem_full), 0);
    check("rst mem_empty", int'(mem_empty), 1);
    check("rst mem_addr", int'(mem_addr), 0);
    do_reset();

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      do_kind(vecs[i].kind, vecs[i].len, vecs[i].s, vecs[i].t);
      check_obs($sformatf("vec%0d", i), vecs[i].e);
    end

    // ---- fill to full, reject 17th write, wr_ptr stays at 0 ----
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_model(K_WR, 0, 0, 1, $sformatf("fill%0d", i));
    run_model(K_WR, 0, 0, 1, "write_when_full");
    run_model(K_RD, 1, 0, 2, "read_one_after_full");
    run_model(K_WR, 0, 0, 1, "write_after_wrap");

    // ---- mid-burst abort by active low ----
    do_reset();
    for (int i = 0; i < 3; i++) run_model(K_WR, 0, 0, 1, $sformatf("ab_wr%0d", i));
    stale_cfg = 0; time_cfg = 6;
    mode = 1'b1; rw = 1'b0; burst_len = '0; valid_cmd = 1'b1;
    @(posedge clk); #1 valid_cmd = 1'b0;
    wait_load("abort word0");
    @(posedge clk); #1;
    wait_load("abort word1");
    repeat (2) begin @(posedge clk); #1; end
    active = 1'b0;
    @(posedge clk); #1;
    check("abort busy", int'(busy), 0);
    check("abort cmd_err", int'(cmd_err), 1);
    check("abort rd_ptr", int'(mem_addr), 2);
    check("abort empty", int'(mem_empty), 0);
    active = 1'b1; busy_left = 0;
    @(posedge clk); #1;
    check("abort err pulse width", int'(cmd_err), 0);
    m_rp = 2; m_occ = 1;
    run_model(K_RD, 0, 0, 2, "after_abort_read");
    run_model(K_RD, 0, 0, 2, "read_empty");

    // ---- mode change aborts a direct transmit ----
    stale_cfg = 0; time_cfg = 6;
    mode = 1'b0; valid_cmd = 1'b1;
    @(posedge clk); #1 valid_cmd = 1'b0;
    check("dir load", int'(p_load), 1);
    repeat (2) begin @(posedge clk); #1; end
    mode = 1'b1;
    @(posedge clk); #1;
    check("mode abort busy", int'(busy), 0);
    check("mode abort cmd_err", int'(cmd_err), 1);
    busy_left = 0;

    // ---- asynchronous reset in the middle of a burst ----
    do_reset();
    for (int i = 0; i < 2; i++) run_model(K_WR, 0, 0, 1, $sformatf("rs_wr%0d", i));
    stale_cfg = 0; time_cfg = 5;
    mode = 1'b1; rw = 1'b0; burst_len = '0; valid_cmd = 1'b1;
    @(posedge clk); #1 valid_cmd = 1'b0;
    wait_load("reset burst");
    @(posedge clk); #4;
    reset = 1'b1;
    #1;
    check("midrst busy", int'(busy), 0);
    check("midrst ac_mem", int'(ac_mem), 0);
    check("midrst empty", int'(mem_empty), 1);
    check("midrst mem_addr", int'(mem_addr), 0);
    do_reset();

    // ---- stuck transmitter: watchdog (if built in) vs. indefinite wait ----
    run_model(K_WR, 0, 0, 1, "to_wr");
    tx_hang = 1'b1;
    mode = 1'b1; rw = 1'b0; burst_len = '0; valid_cmd = 1'b1;
    @(posedge clk); #1 valid_cmd = 1'b0;
    wait_load("timeout");
    repeat (15) begin @(posedge clk); #1; end
    check("wait15 busy", int'(busy), 1);
    check("wait15 cmd_err", int'(cmd_err), 0);
    @(posedge clk); #1;
`ifdef CTRL_TIMEOUT_EN
    check("wait16 busy", int'(busy), 0);
    check("wait16 cmd_err", int'(cmd_err), 1);
`else
    check("wait16 busy", int'(busy), 1);
    check("wait16 cmd_err", int'(cmd_err), 0);
`endif
    tx_hang = 1'b0; busy_left = 0;
    begin
      bit idle_seen;
      idle_seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (!busy) begin idle_seen = 1'b1; break; end
        @(posedge clk); #1;
      end
      check("release idle", int'(idle_seen), 1);
    end
    check("timeout empty", int'(mem_empty), 1);
    m_rp = 1; m_occ = 0;

    // ---- randomized commands against the model ----
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int r, kind;
      r = $urandom_range(0, 9);
      kind = (r < 5) ? K_WR : (r < 8) ? K_RD : (r == 8) ? K_DIR : K_OFF;
      run_model(kind, $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(1, 4),
                $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
